// File: rtl/decoder_scan_nx.sv
// -----------------------------------------------------------------------------
// decoder_scan_nx
//
// Registered N-to-2**N one-hot (or one-cold) decoder with two operating modes:
//   DIRECT : decodes sel with one cycle of latency.
//   SCAN   : free-running sequencer. It starts at sel and advances one index
//            every PRESCALE cycles, wrapping from 2**N-1 back to 0.
//
// Parameters
//   N          select width; the decoder has 2**N outputs (N >= 1)
//   PRESCALE   cycles each index is held in SCAN (PRESCALE >= 1)
//   ACTIVE_LOW 1: D is one-cold (selected bit 0). 0: D is one-hot
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   en    in   1 = active, 0 = all D bits inactive and idx frozen
//   mode  in   0 = DIRECT, 1 = SCAN
//   sel   in   DIRECT: index to decode. SCAN: start index loaded on entry
//   D     out  registered decoded output
//   idx   out  registered index currently shown on D (always active-high)
//   wrap  out  one-cycle pulse after SCAN steps from 2**N-1 to 0
// -----------------------------------------------------------------------------
module decoder_scan_nx #(
  parameter int unsigned N          = 2,
  parameter int unsigned PRESCALE   = 4,
  parameter int unsigned ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      sel,
  output logic [2**N-1:0]   D,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int unsigned W  = 2**N;
  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [CW-1:0] CntLast = CW'(PRESCALE - 1);
  localparam logic [W-1:0]  DOff    = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

  typedef enum logic [1:0] {
    StIdle,
    StDirect,
    StScan
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    idx_inc;

  // Polarity is folded in here so D is always a direct register load.
  function automatic logic [W-1:0] decode(input logic [N-1:0] i);
    logic [W-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return (ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  assign idx_inc = idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx     <= '0;
      cnt_q   <= '0;
      wrap    <= 1'b0;
      D       <= DOff;
    end else if (!en) begin
      // idx deliberately keeps its last value while disabled.
      state_q <= StIdle;
      cnt_q   <= '0;
      wrap    <= 1'b0;
      D       <= DOff;
    end else if (!mode) begin
      state_q <= StDirect;
      idx     <= sel;
      D       <= decode(sel);
      cnt_q   <= '0;
      wrap    <= 1'b0;
    end else begin
      unique case (state_q)
        StScan: begin
          if (cnt_q == CntLast) begin
            cnt_q <= '0;
            idx   <= idx_inc;
            D     <= decode(idx_inc);
            wrap  <= (idx == {N{1'b1}});
          end else begin
            cnt_q <= cnt_q + 1'b1;
            wrap  <= 1'b0;
          end
        end
        default: begin
          // Entry from IDLE or DIRECT always reloads from sel; no wrap pulse
          // even when sel is 0.
          state_q <= StScan;
          idx     <= sel;
          D       <= decode(sel);
          cnt_q   <= '0;
          wrap    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_scan_nx.sv
module tb_decoder_scan_nx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  // Instance A: N=2, PRESCALE=4, active-high
  logic       en_a   = 1'b0;
  logic       mode_a = 1'b0;
  logic [1:0] sel_a  = '0;
  logic [3:0] d_a;
  logic [1:0] idx_a;
  logic       wrap_a;

  // Instance B: N=3, PRESCALE=1, active-low
  logic       en_b   = 1'b0;
  logic       mode_b = 1'b0;
  logic [2:0] sel_b  = '0;
  logic [7:0] d_b;
  logic [2:0] idx_b;
  logic       wrap_b;

  int compared   = 0;
  int mismatched = 0;

  decoder_scan_nx #(.N(2), .PRESCALE(4), .ACTIVE_LOW(0)) dut_a (
    .clk  (clk),
    .rst  (rst),
    .en   (en_a),
    .mode (mode_a),
    .sel  (sel_a),
    .D    (d_a),
    .idx  (idx_a),
    .wrap (wrap_a)
  );

  decoder_scan_nx #(.N(3), .PRESCALE(1), .ACTIVE_LOW(1)) dut_b (
    .clk  (clk),
    .rst  (rst),
    .en   (en_b),
    .mode (mode_b),
    .sel  (sel_b),
    .D    (d_b),
    .idx  (idx_b),
    .wrap (wrap_b)
  );

  initial forever #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [3:0] d, input logic [1:0] i,
                       input logic w);
    chk({tag, ".D"},    {4'b0, d_a},    {4'b0, d});
    chk({tag, ".idx"},  {6'b0, idx_a},  {6'b0, i});
    chk({tag, ".wrap"}, {7'b0, wrap_a}, {7'b0, w});
  endtask

  task automatic chk_b(input string tag, input logic [7:0] d, input logic [2:0] i,
                       input logic w);
    chk({tag, ".D"},    d_b,            d);
    chk({tag, ".idx"},  {5'b0, idx_b},  {5'b0, i});
    chk({tag, ".wrap"}, {7'b0, wrap_b}, {7'b0, w});
  endtask

  initial begin
    logic [1:0] ei;
    logic [3:0] ed;

    // 1. Asynchronous reset before any clock edge (first posedge at t=5).
    #2 rst = 1'b1;
    #1;
    chk_a("reset_async", 4'b0000, 2'd0, 1'b0);
    chk_b("reset_async_b", 8'hFF, 3'd0, 1'b0);
    #4 rst = 1'b0;
    tick();
    chk_a("idle", 4'b0000, 2'd0, 1'b0);
    chk_b("idle_b", 8'hFF, 3'd0, 1'b0);

    // 2. DIRECT decoding.
    en_a = 1'b1; mode_a = 1'b0; sel_a = 2'd2;
    tick();
    chk_a("direct_sel2", 4'b0100, 2'd2, 1'b0);
    sel_a = 2'd3;
    tick();
    chk_a("direct_sel3", 4'b1000, 2'd3, 1'b0);
    sel_a = 2'd0;
    tick();
    chk_a("direct_sel0_nowrap", 4'b0001, 2'd0, 1'b0);

    // 3/4. SCAN from sel=1; each index held 4 cycles; wrap on first 0 cycle.
    mode_a = 1'b1; sel_a = 2'd1;
    for (int k = 0; k <= 20; k++) begin
      tick();
      if (k == 0) sel_a = 2'd0;  // ignored until the next SCAN entry
      ei = 2'((1 + k / 4) % 4);
      ed = 4'b0001 << ei;
      chk_a($sformatf("scan_k%0d", k), ed, ei, (k == 12));
    end

    // Drop en at idx=2: D inactive next edge, idx frozen.
    en_a = 1'b0;
    tick();
    chk_a("en_drop", 4'b0000, 2'd2, 1'b0);
    tick();
    chk_a("en_drop_hold", 4'b0000, 2'd2, 1'b0);

    // Re-enable in SCAN with sel=3: reload and restart count.
    en_a = 1'b1; sel_a = 2'd3;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_a($sformatf("reenable_k%0d", k), 4'b1000, 2'd3, 1'b0);
    end
    tick();
    chk_a("reenable_wrap", 4'b0001, 2'd0, 1'b1);

    // 5. Reset mid-scan between clock edges, with wrap currently high.
    #2 rst = 1'b1;
    #1;
    chk_a("reset_midscan", 4'b0000, 2'd0, 1'b0);
    en_a = 1'b0;
    #2 rst = 1'b0;
    tick();
    chk_a("post_reset_idle", 4'b0000, 2'd0, 1'b0);
    tick();
    chk_a("post_reset_idle2", 4'b0000, 2'd0, 1'b0);

    // Mode change mid-scan takes effect on the next edge.
    en_a = 1'b1; mode_a = 1'b1; sel_a = 2'd2;
    tick();
    chk_a("scan_entry2", 4'b0100, 2'd2, 1'b0);
    mode_a = 1'b0; sel_a = 2'd0;
    tick();
    chk_a("scan_to_direct", 4'b0001, 2'd0, 1'b0);
    mode_a = 1'b1; sel_a = 2'd0;
    tick();
    chk_a("direct_to_scan_sel0", 4'b0001, 2'd0, 1'b0);

    // 6. N=3, PRESCALE=1, active-low SCAN from sel=6.
    en_b = 1'b1; mode_b = 1'b1; sel_b = 3'd6;
    tick();
    chk_b("b_scan6", 8'b10111111, 3'd6, 1'b0);
    tick();
    chk_b("b_scan7", 8'b01111111, 3'd7, 1'b0);
    tick();
    chk_b("b_scan0_wrap", 8'b11111110, 3'd0, 1'b1);
    tick();
    chk_b("b_scan1", 8'b11111101, 3'd1, 1'b0);
    en_b = 1'b0;
    tick();
    chk_b("b_en_drop", 8'hFF, 3'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
